alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the shared package.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream handshake; a transfer occurs when both are high at a rising edge.
REQ-005 in_op  input  3  opcode: 000 add, 001 sub, all others illegal.
REQ-006 in_a / in_b  input  4 / 4  operands.
REQ-007 adder_a / adder_b  output  4 / 4  operands driven to the downstream full_adder.
REQ-008 adder_out / adder_carry / adder_zero / adder_parity / adder_sign / adder_overflow  input  8/1/1/1/1/1  combinational adder results.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 out_res / out_carry / out_zero / out_parity / out_sign / out_overflow / out_err  output  8/1/1/1/1/1/1  result and flags.
REQ-011 clr_sticky / sticky_carry / sticky_ovf  input / output / output  1/1/1  sticky flag clear and status.

Function
REQ-012 Accepted op SHALL load a stage-1 register (s1_valid, op, a, b_eff) at the accepting edge.
REQ-013 b_eff SHALL be in_b for add and (~in_b + 1) mod 16 for sub; adder_a/adder_b SHALL be driven from stage-1 registers, 0 when s1_valid=0.
REQ-014 While s1_valid=1, adder results SHALL be captured into a 2-entry in-order output FIFO on the next edge; latency accept-edge to out_valid = 2 cycles.
REQ-015 Add: out_* SHALL equal the adder's outputs unchanged; out_err=0.
REQ-016 Sub: out_carry SHALL be borrow = ~adder_carry, except 0 when b=0; out_overflow SHALL be ~a[3] when b=1000, else adder_overflow; other flags from the adder.
REQ-017 Illegal op: out_res=0, out_zero=1, out_err=1, all other flags 0; adder results ignored.
REQ-018 in_ready SHALL be (fifo_count + s1_valid - (out_valid & out_ready)) < 2; combinational path out_ready->in_ready permitted.
REQ-019 With out_ready held high, SHALL sustain one accepted op per cycle.
REQ-020 out_valid = FIFO non-empty; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous FIFO push and pop SHALL keep count unchanged and preserve order.
REQ-022 FIFO SHALL never overflow; push into a full FIFO is unreachable by REQ-018 and SHALL be asserted against.

Reset
REQ-023 On rst_n low: s1_valid=0, FIFO empty, out_valid=0, in_ready=0 while rst_n low, all out_* and adder_* = 0, sticky flags = 0.
REQ-024 Reset mid-operation SHALL discard all in-flight ops; first accept possible on the first edge after rst_n deasserts.

Configuration
REQ-025 Macro ALU_ISSUE_STICKY_EN: when defined, sticky_carry/sticky_ovf SHALL OR in out_carry/out_overflow of each popped result and clear on clr_sticky; set wins over simultaneous clear.
REQ-026 When undefined, sticky outputs SHALL be tied 0 and clr_sticky ignored; no sticky flops.

Structure
REQ-027 Shared package alu_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB), operand width 4, result width 8, and the result/flag struct.
REQ-028 The output FIFO SHALL be a sub-module alu_out_fifo (depth 2, payload = result struct).

Verification
REQ-029 add a=0111 b=1001, out_ready=1 -> 2 cycles later out_res=0x00, carry=1, zero=1, parity=0, sign=0, overflow=0, err=0.
REQ-030 sub a=0011 b=0101 -> adder_b=1011, out_res=0x0E, carry(borrow)=1, sign=1, overflow=0.
REQ-031 sub a=0000 b=1000 -> out_res=0x08, overflow=1, borrow=1; sub a=0101 b=0000 -> out_res=0x05, borrow=0.
REQ-032 out_ready=0, issue three adds back-to-back -> two accepted, in_ready=0 for third; raise out_ready -> three results in issue order, no loss.
REQ-033 op=010 a=1111 b=1111 -> out_res=0, zero=1, err=1; with ALU_ISSUE_STICKY_EN, carry result pop coincident with clr_sticky -> sticky_carry=1.
REQ-034 Assert rst_n low with two ops in flight -> out_valid=0 next cycle, no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue stage.
package alu_pkg;

  localparam int unsigned OPERAND_W  = 4;
  localparam int unsigned RESULT_W   = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  // Most negative operand; its negation is not representable in OPERAND_W bits.
  localparam logic [OPERAND_W-1:0] OPERAND_MIN_NEG = 4'b1000;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001
  } alu_op_e;

  typedef struct packed {
    logic [RESULT_W-1:0] res;
    logic                carry;
    logic                zero;
    logic                parity;
    logic                sign;
    logic                overflow;
    logic                err;
  } alu_res_t;

  // Two's-complement negation, modulo 2**OPERAND_W.
  function automatic logic [OPERAND_W-1:0] twos_neg(input logic [OPERAND_W-1:0] v);
    return ~v + OPERAND_W'(1);
  endfunction

endpackage

// File: rtl/alu_out_fifo.sv
// Two-entry in-order result FIFO; head reads as zero while empty.
module alu_out_fifo
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_res_t push_data,
  input  logic     pop,
  output logic [1:0] count,
  output logic     empty,
  output alu_res_t head
);

  alu_res_t   mem_q [FIFO_DEPTH];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       full, push_ok, pop_ok;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy tracking; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Upstream credit logic must never let stage 1 push into a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: registers an add/sub op, drives an external adder, fixes up
// subtract flags and queues results in a 2-entry FIFO.
// Optional build macro ALU_ISSUE_STICKY_EN adds sticky carry/overflow status.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  output logic [OPERAND_W-1:0] adder_a,
  output logic [OPERAND_W-1:0] adder_b,
  input  logic [RESULT_W-1:0]  adder_out,
  input  logic                 adder_carry,
  input  logic                 adder_zero,
  input  logic                 adder_parity,
  input  logic                 adder_sign,
  input  logic                 adder_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RESULT_W-1:0]  out_res,
  output logic                 out_carry,
  output logic                 out_zero,
  output logic                 out_parity,
  output logic                 out_sign,
  output logic                 out_overflow,
  output logic                 out_err,
  input  logic                 clr_sticky,
  output logic                 sticky_carry,
  output logic                 sticky_ovf
);

  logic                 s1_valid_q;
  logic [2:0]           s1_op_q;
  logic [OPERAND_W-1:0] s1_a_q, s1_b_q;

  logic       accept, pop, fifo_empty;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  alu_res_t   s1_res, head;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Slots committed after this edge: FIFO + stage 1 - departing head.
  assign occupancy = {1'b0, fifo_count} + {2'b00, s1_valid_q} - {2'b00, pop};
  assign in_ready  = rst_n & (occupancy < 3'd2);
  assign accept    = in_valid & in_ready;

  // Stage-1 register; subtract stores the negated b so the adder only adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 3'b000;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q <= in_op;
        s1_a_q  <= in_a;
        s1_b_q  <= (in_op == OP_SUB) ? twos_neg(in_b) : in_b;
      end
    end
  end

  assign adder_a = s1_valid_q ? s1_a_q : '0;
  assign adder_b = s1_valid_q ? s1_b_q : '0;

  // Result formation from adder outputs, with subtract flag corrections.
  always_comb begin
    s1_res = '0;
    case (s1_op_q)
      OP_ADD: begin
        s1_res.res      = adder_out;
        s1_res.carry    = adder_carry;
        s1_res.zero     = adder_zero;
        s1_res.parity   = adder_parity;
        s1_res.sign     = adder_sign;
        s1_res.overflow = adder_overflow;
      end
      OP_SUB: begin
        s1_res.res    = adder_out;
        // b_eff is zero exactly when b is zero; a - 0 never borrows.
        s1_res.carry  = (s1_b_q == '0) ? 1'b0 : ~adder_carry;
        s1_res.zero   = adder_zero;
        s1_res.parity = adder_parity;
        s1_res.sign   = adder_sign;
        // -(-8) wraps to -8, so the adder's overflow is wrong for that b.
        s1_res.overflow = (s1_b_q == OPERAND_MIN_NEG) ? ~s1_a_q[OPERAND_W-1] : adder_overflow;
      end
      default: begin
        s1_res.zero = 1'b1;
        s1_res.err  = 1'b1;
      end
    endcase
  end

  alu_out_fifo u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid_q),
    .push_data (s1_res),
    .pop       (pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_res      = head.res;
  assign out_carry    = head.carry;
  assign out_zero     = head.zero;
  assign out_parity   = head.parity;
  assign out_sign     = head.sign;
  assign out_overflow = head.overflow;
  assign out_err      = head.err;

`ifdef ALU_ISSUE_STICKY_EN
  logic sticky_carry_q, sticky_ovf_q;

  // Sticky status accumulates popped flags; a set in the same cycle beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
    end else begin
      sticky_carry_q <= (sticky_carry_q & ~clr_sticky) | (pop & out_carry);
      sticky_ovf_q   <= (sticky_ovf_q & ~clr_sticky) | (pop & out_overflow);
    end
  end

  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_carry      = 1'b0;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural adder and a
// queue-based reference model computed from signed/unsigned arithmetic.
module tb_alu_issue_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a, in_b;
  logic [3:0] adder_a, adder_b;
  logic [7:0] adder_out;
  logic       adder_carry, adder_zero, adder_parity, adder_sign, adder_overflow;
  logic       out_valid, out_ready;
  logic [7:0] out_res;
  logic       out_carry, out_zero, out_parity, out_sign, out_overflow, out_err;
  logic       clr_sticky, sticky_carry, sticky_ovf;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .adder_a        (adder_a),
    .adder_b        (adder_b),
    .adder_out      (adder_out),
    .adder_carry    (adder_carry),
    .adder_zero     (adder_zero),
    .adder_parity   (adder_parity),
    .adder_sign     (adder_sign),
    .adder_overflow (adder_overflow),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_res        (out_res),
    .out_carry      (out_carry),
    .out_zero       (out_zero),
    .out_parity     (out_parity),
    .out_sign       (out_sign),
    .out_overflow   (out_overflow),
    .out_err        (out_err),
    .clr_sticky     (clr_sticky),
    .sticky_carry   (sticky_carry),
    .sticky_ovf     (sticky_ovf)
  );

  // Downstream 4-bit full adder, result zero-extended to 8 bits.
  logic [4:0] add_sum;
  assign add_sum        = {1'b0, adder_a} + {1'b0, adder_b};
  assign adder_out      = {4'h0, add_sum[3:0]};
  assign adder_carry    = add_sum[4];
  assign adder_zero     = (add_sum[3:0] == 4'h0);
  assign adder_parity   = ^add_sum[3:0];
  assign adder_sign     = add_sum[3];
  assign adder_overflow = (adder_a[3] == adder_b[3]) && (add_sum[3] != adder_a[3]);

  // Reference model state: stage-1 slot plus an in-order result queue.
  logic [13:0] m_q[$];
  bit          m_s1_v;
  logic [3:0]  m_s1_a, m_s1_b;
  logic [13:0] m_s1_r;
  bit          m_sc, m_so;
  int          m_accepts;

  // Expected {res[7:0], carry, zero, parity, sign, overflow, err} from plain arithmetic.
  function automatic logic [13:0] ref_result(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
    int sa, sb, r, d;
    logic [3:0] res4;
    logic c, o;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    case (op)
      3'b000: begin
        r = int'(a) + int'(b);
        c = (r >= 16);
        d = sa + sb;
      end
      3'b001: begin
        r = int'(a) - int'(b);
        c = (a < b);
        d = sa - sb;
      end
      default: return {8'h00, 6'b010001};
    endcase
    res4 = r[3:0];
    o = (d > 7) || (d < -8);
    return {4'h0, res4, c, (res4 == 4'h0), ^res4, res4[3], o, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_s1_v = 1'b0;
    m_s1_a = '0;
    m_s1_b = '0;
    m_s1_r = '0;
    m_sc   = 1'b0;
    m_so   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_bus"}, {out_res, out_carry, out_zero, out_parity, out_sign,
                            out_overflow, out_err}, 0);
    chk({tag, "_adder"}, {adder_a, adder_b}, 0);
    chk({tag, "_sticky"}, {sticky_carry, sticky_ovf}, 0);
  endtask

  // One clock: drive at negedge, compare against model, then advance the model.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input bit ordy, input bit clr);
    bit m_ready, m_pop;
    logic [13:0] exp_head, popped;
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; clr_sticky = clr;
    #1;
    m_pop    = ordy && (m_q.size() > 0);
    m_ready  = (int'(m_q.size()) + int'(m_s1_v) - int'(m_pop)) < 2;
    exp_head = (m_q.size() > 0) ? m_q[0] : 14'h0;
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, (m_q.size() > 0));
    chk("out_bus", {out_res, out_carry, out_zero, out_parity, out_sign, out_overflow, out_err},
        exp_head);
    chk("adder_ops", {adder_a, adder_b}, m_s1_v ? {m_s1_a, m_s1_b} : 8'h00);
    chk("sticky", {sticky_carry, sticky_ovf}, {m_sc, m_so});
    @(posedge clk);
`ifdef ALU_ISSUE_STICKY_EN
    if (clr) begin
      m_sc = 1'b0;
      m_so = 1'b0;
    end
`endif
    if (m_pop) begin
      popped = m_q.pop_front();
`ifdef ALU_ISSUE_STICKY_EN
      m_sc = m_sc | popped[5];
      m_so = m_so | popped[1];
`endif
    end
    if (m_s1_v) m_q.push_back(m_s1_r);
    m_s1_v = v && m_ready;
    if (m_s1_v) begin
      m_accepts++;
      m_s1_a = a;
      m_s1_b = (op == 3'b001) ? 4'((16 - int'(b)) % 16) : b;
      m_s1_r = ref_result(op, a, b);
    end
    @(negedge clk);
  endtask

  // Issue a single op, hold it at the FIFO head, compare to a fixed value, drain.
  task automatic directed(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [13:0] exp);
    cycle(1'b1, op, a, b, 1'b0, 1'b0);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 1'b0);
    chk(tag, {out_res, out_carry, out_zero, out_parity, out_sign, out_overflow, out_err}, exp);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_sc;
    int acc0;
    logic [2:0] rop;
    checks = 0; errors = 0; m_accepts = 0;
    model_reset();
    in_valid = 1'b1; in_op = 3'b000; in_a = 4'h3; in_b = 4'h4;
    out_ready = 1'b1; clr_sticky = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Adds, subtracts and an illegal op against fixed expectations.
    directed("req029_add", 3'b000, 4'b0111, 4'b1001, {8'h00, 6'b110000});
    cycle(1'b1, 3'b001, 4'b0011, 4'b0101, 1'b0, 1'b0);
    chk("req030_adder_b", adder_b, 4'b1011);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("req030_sub", {out_res, out_carry, out_zero, out_parity, out_sign, out_overflow,
                       out_err}, {8'h0E, 6'b101100});
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);
    directed("req031_sub_min", 3'b001, 4'b0000, 4'b1000, {8'h08, 6'b101110});
    directed("req031_sub_zero", 3'b001, 4'b0101, 4'b0000, {8'h05, 6'b000000});
    directed("req033_illegal", 3'b010, 4'b1111, 4'b1111, {8'h00, 6'b010001});

    // Back-pressure: third op stalls, then all three drain in order.
    acc0 = m_accepts;
    cycle(1'b1, 3'b000, 4'h1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 4'h3, 4'h4, 1'b0, 1'b0);
    chk("req032_third_blocked", in_ready, 0);
    cycle(1'b1, 3'b000, 4'h5, 4'h6, 1'b0, 1'b0);
    chk("req032_two_accepted", m_accepts - acc0, 2);
    cycle(1'b1, 3'b000, 4'h5, 4'h6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);

    // Full throughput with out_ready held high.
    acc0 = m_accepts;
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i % 2), 4'(i), 4'(15 - i), 1'b1, 1'b0);
    chk("req019_throughput", m_accepts - acc0, 8);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);

    // Carry pop coincident with clear: set wins.
    cycle(1'b1, 3'b000, 4'b0111, 4'b1001, 1'b0, 1'b0);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b1);
`ifdef ALU_ISSUE_STICKY_EN
    exp_sc = 1'b1;
`else
    exp_sc = 1'b0;
`endif
    chk("req033_sticky_set_wins", sticky_carry, exp_sc);
    cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("sticky_cleared", sticky_carry, 0);

    // Reset with two ops in flight.
    cycle(1'b1, 3'b000, 4'h1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 3'b001, 4'h2, 4'h3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("req034_mid_reset");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cycle(1'b1, 3'b000, 4'h2, 4'h2, 1'b1, 1'b0);
    chk("req034_first_accept", adder_a, 4'h2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 9) < 4) ? 3'b000 :
            ($urandom_range(0, 5) < 4) ? 3'b001 : 3'($urandom);
      cycle(($urandom_range(0, 3) != 0), rop, 4'($urandom), 4'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
